matrix_alu_arb: RTL and testbench

MATRIX_ALU_ARB -- requirements
Module: matrix_alu_arb

---
 rtl/matrix_alu_pkg.sv | 17 +
 rtl/matrix_alu_rr_arb.sv | 17 +
 rtl/matrix_alu_arb.sv | 142 ++++++++++++++
 tb/tb_matrix_alu_arb.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_alu_pkg.sv
// Shared op encodings and controller state enumeration for the matrix ALU arbiter.
package matrix_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_KRO = 2'b11;

  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/matrix_alu_rr_arb.sv
// Two-way round-robin grant: ptr names the requester favoured when both request.
module matrix_alu_rr_arb (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || !ptr)) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/matrix_alu_arb.sv
// Two-requester round-robin front end for a shared, externally instantiated matrix ALU.
// Optional per-requester completed-response counters: define MATRIX_ALU_ARB_STATS_EN.
module matrix_alu_arb
  import matrix_alu_pkg::*;
#(
  parameter  int WORD_SIZE = 8,
  parameter  int AROWS     = 2,
  parameter  int ACOLS     = 2,
  parameter  int BROWS     = 2,
  parameter  int BCOLS     = 2,
  parameter  int ALU_LAT   = 1,
  localparam int AW        = AROWS * ACOLS * WORD_SIZE,
  localparam int BW        = BROWS * BCOLS * WORD_SIZE,
  localparam int CW        = AROWS * ACOLS * BROWS * BCOLS * WORD_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_0,
  output logic              req_ready_0,
  input  logic [1:0]        req_op_0,
  input  logic [AW-1:0]     req_a_0,
  input  logic [BW-1:0]     req_b_0,
  input  logic              req_valid_1,
  output logic              req_ready_1,
  input  logic [1:0]        req_op_1,
  input  logic [AW-1:0]     req_a_1,
  input  logic [BW-1:0]     req_b_1,
  output logic              rsp_valid_0,
  input  logic              rsp_ready_0,
  output logic              rsp_valid_1,
  input  logic              rsp_ready_1,
  output logic [CW-1:0]     rsp_c,
  output logic [1:0]        alu_op,
  output logic [AW-1:0]     alu_a,
  output logic [BW-1:0]     alu_b,
  output logic              busy,
`ifdef MATRIX_ALU_ARB_STATS_EN
  output logic [STAT_W-1:0] stat_cnt_0,
  output logic [STAT_W-1:0] stat_cnt_1,
`endif
  input  logic [CW-1:0]     alu_c
);

  localparam logic [4:0] CNT_LAST = 5'(ALU_LAT + 1);

  state_t        state;
  logic          rr_ptr;
  logic          win_id;
  logic [4:0]    cnt;
  logic [1:0]    req_vec;
  logic [1:0]    grant;
  logic          rsp_done;

  logic [1:0]    op_p0;
  logic [AW-1:0] a_p0;
  logic [BW-1:0] b_p0;
  logic [CW-1:0] c_p1;

  assign req_vec = {req_valid_1, req_valid_0};

  matrix_alu_rr_arb u_rr_arb (
    .req   (req_vec),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign req_ready_0 = (state == IDLE) && !reset && grant[0];
  assign req_ready_1 = (state == IDLE) && !reset && grant[1];
  assign rsp_done    = (state == RESP) && (win_id ? rsp_ready_1 : rsp_ready_0);
  assign busy        = (state != IDLE);

  assign alu_op = op_p0;
  assign alu_a  = a_p0;
  assign alu_b  = b_p0;
  assign rsp_c  = c_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      win_id      <= 1'b0;
      cnt         <= '0;
      op_p0       <= '0;
      a_p0        <= '0;
      b_p0        <= '0;
      c_p1        <= '0;
      rsp_valid_0 <= 1'b0;
      rsp_valid_1 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // p0: winner's operands latched on the accept edge only
          if (|grant) begin
            op_p0  <= grant[1] ? req_op_1 : req_op_0;
            a_p0   <= grant[1] ? req_a_1  : req_a_0;
            b_p0   <= grant[1] ? req_b_1  : req_b_0;
            win_id <= grant[1];
            cnt    <= '0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          // p1: result captured once the ALU output has settled
          if (cnt == CNT_LAST) begin
            c_p1        <= alu_c;
            rsp_valid_0 <= !win_id;
            rsp_valid_1 <= win_id;
            state       <= RESP;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        RESP: begin
          if (rsp_done) begin
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
            rr_ptr      <= !win_id;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MATRIX_ALU_ARB_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_cnt_0 <= '0;
      stat_cnt_1 <= '0;
    end else if (rsp_done) begin
      if (win_id) stat_cnt_1 <= sat_inc(stat_cnt_1);
      else        stat_cnt_0 <= sat_inc(stat_cnt_0);
    end
  end
`endif

endmodule

// File: tb/tb_matrix_alu_arb.sv
// Bench for matrix_alu_arb: behavioural ALU, transaction-level reference model, directed and random stimulus.
`timescale 1ns/1ps
module tb_matrix_alu_arb;
  import matrix_alu_pkg::*;

  localparam int W   = 8;
  localparam int AR  = 2;
  localparam int AC  = 2;
  localparam int BR  = 2;
  localparam int BC  = 2;
  localparam int LAT = 1;
  localparam int AW  = AR * AC * W;
  localparam int BW  = BR * BC * W;
  localparam int CW  = AR * AC * BR * BC * W;

  logic          clk, reset;
  logic          req_valid_0, req_ready_0, req_valid_1, req_ready_1;
  logic [1:0]    req_op_0, req_op_1;
  logic [AW-1:0] req_a_0, req_a_1;
  logic [BW-1:0] req_b_0, req_b_1;
  logic          rsp_valid_0, rsp_ready_0, rsp_valid_1, rsp_ready_1;
  logic [CW-1:0] rsp_c;
  logic [1:0]    alu_op;
  logic [AW-1:0] alu_a;
  logic [BW-1:0] alu_b;
  logic [CW-1:0] alu_c;
  logic          busy;
`ifdef MATRIX_ALU_ARB_STATS_EN
  logic [15:0]   stat_cnt_0, stat_cnt_1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  matrix_alu_arb #(
    .WORD_SIZE (W), .AROWS (AR), .ACOLS (AC), .BROWS (BR), .BCOLS (BC), .ALU_LAT (LAT)
  ) dut (
    .clk (clk), .reset (reset),
    .req_valid_0 (req_valid_0), .req_ready_0 (req_ready_0), .req_op_0 (req_op_0),
    .req_a_0 (req_a_0), .req_b_0 (req_b_0),
    .req_valid_1 (req_valid_1), .req_ready_1 (req_ready_1), .req_op_1 (req_op_1),
    .req_a_1 (req_a_1), .req_b_1 (req_b_1),
    .rsp_valid_0 (rsp_valid_0), .rsp_ready_0 (rsp_ready_0),
    .rsp_valid_1 (rsp_valid_1), .rsp_ready_1 (rsp_ready_1),
    .rsp_c (rsp_c), .alu_op (alu_op), .alu_a (alu_a), .alu_b (alu_b), .busy (busy),
`ifdef MATRIX_ALU_ARB_STATS_EN
    .stat_cnt_0 (stat_cnt_0), .stat_cnt_1 (stat_cnt_1),
`endif
    .alu_c (alu_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Element (r,c) of an R x C matrix lives at bits [(r*C+c)*W +: W].
  function automatic logic [CW-1:0] alu_model(input logic [1:0] op, input logic [AW-1:0] a,
                                               input logic [BW-1:0] b);
    logic [CW-1:0] c;
    logic [W-1:0]  acc;
    c = '0;
    case (op)
      OP_ADD, OP_SUB: begin
        for (int e = 0; e < AR * AC; e++)
          c[e*W +: W] = (op == OP_ADD) ? a[e*W +: W] + b[e*W +: W] : a[e*W +: W] - b[e*W +: W];
      end
      OP_MUL: begin
        for (int r = 0; r < AR; r++)
          for (int cc = 0; cc < BC; cc++) begin
            acc = '0;
            for (int k = 0; k < AC; k++)
              acc = acc + a[(r*AC+k)*W +: W] * b[(k*BC+cc)*W +: W];
            c[(r*BC+cc)*W +: W] = acc;
          end
      end
      default: begin
        for (int ra = 0; ra < AR; ra++)
          for (int ca = 0; ca < AC; ca++)
            for (int rb = 0; rb < BR; rb++)
              for (int cb = 0; cb < BC; cb++)
                c[((ra*BR+rb)*(AC*BC) + ca*BC + cb)*W +: W] =
                  a[(ra*AC+ca)*W +: W] * b[(rb*BC+cb)*W +: W];
      end
    endcase
    return c;
  endfunction

  // External ALU: result registered LAT cycles after its inputs.
  logic [CW-1:0] alu_pipe [LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_model(alu_op, alu_a, alu_b);
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_c = alu_pipe[LAT-1];

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding job, fixed latency, round-robin on ties.
  int            cyc = 0;
  int            m_owner = -1;
  int            m_rsp_cyc = 0;
  int            m_fav = 0;
  int            m_stat [2] = '{0, 0};
  logic [1:0]    m_op = '0;
  logic [AW-1:0] m_a = '0;
  logic [BW-1:0] m_b = '0;
  logic [CW-1:0] m_res = '0;
  logic [1:0]    rv, e_rdy, e_rv;
  logic          e_busy;
  int            w;

  always @(negedge clk) begin
    rv     = {req_valid_1, req_valid_0};
    e_rdy  = 2'b00;
    e_rv   = 2'b00;
    e_busy = 1'b0;
    if (!reset) begin
      if (m_owner < 0) begin
        e_rdy = (rv == 2'b11) ? ((m_fav == 1) ? 2'b10 : 2'b01) : rv;
      end else begin
        e_busy = 1'b1;
        if (cyc >= m_rsp_cyc) e_rv = (m_owner == 1) ? 2'b10 : 2'b01;
      end
    end
    chk("req_ready", CW'({req_ready_1, req_ready_0}), CW'(e_rdy));
    chk("rsp_valid", CW'({rsp_valid_1, rsp_valid_0}), CW'(e_rv));
    chk("busy", CW'(busy), CW'(e_busy));
    chk("alu_op", CW'(alu_op), reset ? '0 : CW'(m_op));
    chk("alu_a", CW'(alu_a), reset ? '0 : CW'(m_a));
    chk("alu_b", CW'(alu_b), reset ? '0 : CW'(m_b));
    if (reset) chk("rsp_c_rst", rsp_c, '0);
    else if (e_rv != 2'b00) chk("rsp_c", rsp_c, m_res);
`ifdef MATRIX_ALU_ARB_STATS_EN
    chk("stat_cnt_0", CW'(stat_cnt_0), reset ? '0 : CW'(m_stat[0]));
    chk("stat_cnt_1", CW'(stat_cnt_1), reset ? '0 : CW'(m_stat[1]));
`endif
    if (reset) begin
      m_owner = -1; m_fav = 0; m_op = '0; m_a = '0; m_b = '0; m_res = '0;
      m_stat[0] = 0; m_stat[1] = 0;
    end else if (m_owner < 0) begin
      if (rv != 2'b00) begin
        w         = (rv == 2'b11) ? m_fav : (rv[1] ? 1 : 0);
        m_op      = (w == 1) ? req_op_1 : req_op_0;
        m_a       = (w == 1) ? req_a_1 : req_a_0;
        m_b       = (w == 1) ? req_b_1 : req_b_0;
        m_res     = alu_model(m_op, m_a, m_b);
        m_rsp_cyc = cyc + LAT + 3;
        m_owner   = w;
      end
    end else if (cyc >= m_rsp_cyc && ((m_owner == 1) ? rsp_ready_1 : rsp_ready_0)) begin
      if (m_stat[m_owner] < 65535) m_stat[m_owner] = m_stat[m_owner] + 1;
      m_fav   = 1 - m_owner;
      m_owner = -1;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int n, input logic v, input logic [1:0] op,
                           input logic [AW-1:0] a, input logic [BW-1:0] b);
    if (n == 0) begin
      req_valid_0 = v; req_op_0 = op; req_a_0 = a; req_b_0 = b;
    end else begin
      req_valid_1 = v; req_op_1 = op; req_a_1 = a; req_b_1 = b;
    end
  endtask

  task automatic wait_accept(input int n);
    bit got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if ((n == 0) ? req_ready_0 : req_ready_1) got = 1;
    end
    chk($sformatf("accept_%0d", n), CW'(got), CW'(1));
    tick();
  endtask

  task automatic wait_rsp(input int n, output int lat, output logic [CW-1:0] c);
    bit got = 0;
    lat = 0;
    while (lat < 40 && !got) begin
      tick();
      lat++;
      if ((n == 0) ? rsp_valid_0 : rsp_valid_1) got = 1;
    end
    chk($sformatf("rsp_arrives_%0d", n), CW'(got), CW'(1));
    c = rsp_c;
  endtask

  task automatic finish_rsp(input int n);
    if (n == 0) rsp_ready_0 = 1'b1; else rsp_ready_1 = 1'b1;
    tick();
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b0;
  endtask

  task automatic do_txn(input int n, input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [BW-1:0] b, output logic [CW-1:0] c);
    int lat;
    drive_req(n, 1'b1, op, a, b);
    wait_accept(n);
    drive_req(n, 1'b0, op, a, b);
    wait_rsp(n, lat, c);
    finish_rsp(n);
  endtask

  function automatic logic [AW-1:0] rand_a();
    logic [AW-1:0] r;
    for (int e = 0; e < AR * AC; e++) r[e*W +: W] = W'($urandom);
    return r;
  endfunction

  function automatic logic [BW-1:0] rand_b();
    logic [BW-1:0] r;
    for (int e = 0; e < BR * BC; e++) r[e*W +: W] = W'($urandom);
    return r;
  endfunction

  localparam logic [AW-1:0] ID2 = 32'h01000001;
  localparam logic [CW-1:0] ID4 = 128'h01000000_00010000_00000100_00000001;

  initial begin
    int            lat;
    logic [CW-1:0] c;
    reset = 1'b1;
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b0;
    drive_req(0, 1'b0, OP_ADD, '0, '0);
    drive_req(1, 1'b0, OP_ADD, '0, '0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Simultaneous requests after reset: 0 first, then 1 wins the next tie.
    drive_req(0, 1'b1, OP_ADD, 32'h11111111, 32'h22222222);
    drive_req(1, 1'b1, OP_SUB, 32'h40404040, 32'h01010101);
    @(negedge clk); #1;
    chk("rr_first_grant", CW'({req_ready_1, req_ready_0}), CW'(2'b01));
    tick();
    wait_rsp(0, lat, c);
    chk("rr_r0_result", c, 128'h33333333);
    finish_rsp(0);
    @(negedge clk); #1;
    chk("rr_second_grant", CW'({req_ready_1, req_ready_0}), CW'(2'b10));
    tick();
    drive_req(1, 1'b0, OP_SUB, '0, '0);
    wait_rsp(1, lat, c);
    chk("rr_r1_result", c, 128'h3F3F3F3F);
    finish_rsp(1);
    wait_accept(0);
    drive_req(0, 1'b0, OP_ADD, '0, '0);
    wait_rsp(0, lat, c);
    finish_rsp(0);

    // Add latency and result.
    drive_req(0, 1'b1, OP_ADD, 32'h01010101, 32'h02020202);
    wait_accept(0);
    drive_req(0, 1'b0, OP_ADD, '0, '0);
    wait_rsp(0, lat, c);
    chk("add_latency", CW'(lat), CW'(3));
    chk("add_result", c, 128'h03030303);
    finish_rsp(0);
    chk("add_idle_busy", CW'(busy), CW'(0));

    // Kronecker of identities, held under back-pressure.
    drive_req(1, 1'b1, OP_KRO, ID2, ID2);
    wait_accept(1);
    drive_req(1, 1'b0, OP_KRO, '0, '0);
    wait_rsp(1, lat, c);
    chk("kron_result", c, ID4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("kron_hold_valid", CW'(rsp_valid_1), CW'(1));
      chk("kron_hold_c", rsp_c, ID4);
    end
    finish_rsp(1);

    // Sub wraparound; loser's rsp_ready has no effect.
    drive_req(0, 1'b1, OP_SUB, 32'h05050505, 32'h07070707);
    wait_accept(0);
    drive_req(0, 1'b0, OP_SUB, '0, '0);
    wait_rsp(0, lat, c);
    chk("sub_result", c, 128'hFEFEFEFE);
    rsp_ready_1 = 1'b1;
    repeat (3) tick();
    chk("sub_loser_ready_valid", CW'(rsp_valid_0), CW'(1));
    chk("sub_loser_ready_busy", CW'(busy), CW'(1));
    rsp_ready_1 = 1'b0;
    finish_rsp(0);

    // Reset mid-WAIT abandons the job; next job (mul) completes.
    drive_req(0, 1'b1, OP_MUL, 32'h04030201, 32'h08070605);
    wait_accept(0);
    drive_req(0, 1'b0, OP_MUL, '0, '0);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("rst_busy", CW'(busy), CW'(0));
    chk("rst_rsp_valid", CW'({rsp_valid_1, rsp_valid_0}), CW'(0));
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_no_rsp", CW'(rsp_valid_0), CW'(0));
    end
    drive_req(0, 1'b1, OP_MUL, 32'h04030201, 32'h08070605);
    wait_accept(0);
    drive_req(0, 1'b0, OP_MUL, '0, '0);
    wait_rsp(0, lat, c);
    chk("mul_latency", CW'(lat), CW'(3));
    chk("mul_result", c, 128'h322B1613);
    finish_rsp(0);

    // Response counting after a fresh reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) do_txn(0, OP_ADD, rand_a(), rand_b(), c);
    do_txn(1, OP_MUL, rand_a(), rand_b(), c);
    tick();
`ifdef MATRIX_ALU_ARB_STATS_EN
    chk("stat_r0", CW'(stat_cnt_0), CW'(3));
    chk("stat_r1", CW'(stat_cnt_1), CW'(1));
`endif

    // Random traffic, back-pressure and occasional resets.
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive_req(0, $urandom_range(0, 2) != 0, 2'($urandom), rand_a(), rand_b());
      drive_req(1, $urandom_range(0, 2) != 0, 2'($urandom), rand_a(), rand_b());
      rsp_ready_0 = ($urandom_range(0, 2) == 0);
      rsp_ready_1 = ($urandom_range(0, 2) == 0);
      tick();
    end
    reset = 1'b0;
    drive_req(0, 1'b0, OP_ADD, '0, '0);
    drive_req(1, 1'b0, OP_ADD, '0, '0);
    rsp_ready_0 = 1'b1;
    rsp_ready_1 = 1'b1;
    repeat (10) tick();
    chk("drain_idle", CW'(busy), CW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
